// File: rtl/vec3_normalize.sv
`default_nettype none
// vec3_normalize: Q8.24 3-vector normaliser wrapped around an external fixed-latency inverse-sqrt stage.
// Optional macro NORM_DEGEN_FLAG_EN adds out_degen and zeroes vectors whose squared length is 0.
module vec3_normalize #(
  parameter int WIDTH     = 32,
  parameter int ISQ_LAT   = 2,
  parameter int OUT_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic [WIDTH-1:0] in_z,
  output logic             isq_valid,
  output logic [WIDTH-1:0] isq_x,
  input  logic             isq_valid_in,
  input  logic [WIDTH-1:0] isq_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_x,
  output logic [WIDTH-1:0] out_y,
  output logic [WIDTH-1:0] out_z,
`ifdef NORM_DEGEN_FLAG_EN
  output logic             out_degen,
`endif
  output logic             err
);
  localparam int FRAC = WIDTH - 8;
  localparam int AW   = $clog2(OUT_DEPTH);
  localparam int CW   = AW + 1;
  localparam int VW   = 3 * WIDTH;
  localparam logic [WIDTH-1:0] SAT = '1;

  function automatic logic [WIDTH-1:0] sq_term(input logic [WIDTH-1:0] c);
    logic signed [2*WIDTH-1:0] a;
    logic signed [2*WIDTH-1:0] p;
    a = (2*WIDTH)'($signed(c));
    p = a * a;
    return (|p[2*WIDTH-1:FRAC+WIDTH]) ? SAT : WIDTH'(p >>> FRAC);
  endfunction

  function automatic logic [WIDTH-1:0] scale(input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] r);
    logic signed [2*WIDTH:0] a;
    logic signed [2*WIDTH:0] b;
    logic signed [2*WIDTH:0] p;
    a = (2*WIDTH+1)'($signed(c));
    b = $signed({{(WIDTH+1){1'b0}}, r});
    p = a * b;
    return WIDTH'(p >>> FRAC);
  endfunction

  logic          rdy_en_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          accept, pop;

  // Credits cover everything accepted but not yet popped, so the FIFO never overflows.
  assign in_ready = rdy_en_q && (cnt_q < CW'(OUT_DEPTH));
  assign accept   = in_valid && in_ready;
  assign pop      = out_valid && out_ready;

  always_comb begin
    cnt_d = cnt_q;
    if (accept && !pop)      cnt_d = cnt_q + CW'(1);
    else if (!accept && pop) cnt_d = cnt_q - CW'(1);
  end

  logic              s1_v_q;
  logic [VW-1:0]     s1_t_q, s1_c_q;
  logic              isq_valid_q, s2_zero_q;
  logic [WIDTH-1:0]  isq_x_q;
  logic [VW-1:0]     s2_c_q;
  logic [WIDTH+1:0]  sum_w;
  logic              zero_w;

  assign sum_w = {2'b00, s1_t_q[VW-1:2*WIDTH]} + {2'b00, s1_t_q[2*WIDTH-1:WIDTH]}
               + {2'b00, s1_t_q[WIDTH-1:0]};
`ifdef NORM_DEGEN_FLAG_EN
  assign zero_w = (sum_w == '0);
`else
  assign zero_w = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdy_en_q    <= 1'b0;
      cnt_q       <= '0;
      s1_v_q      <= 1'b0;
      s1_t_q      <= '0;
      s1_c_q      <= '0;
      isq_valid_q <= 1'b0;
      isq_x_q     <= '0;
      s2_c_q      <= '0;
      s2_zero_q   <= 1'b0;
    end else begin
      rdy_en_q    <= 1'b1;
      cnt_q       <= cnt_d;
      s1_v_q      <= accept;
      if (accept) begin
        s1_t_q <= {sq_term(in_x), sq_term(in_y), sq_term(in_z)};
        s1_c_q <= {in_x, in_y, in_z};
      end
      isq_valid_q <= s1_v_q;
      if (s1_v_q) begin
        isq_x_q   <= (|sum_w[WIDTH+1:WIDTH]) ? SAT : sum_w[WIDTH-1:0];
        s2_c_q    <= s1_c_q;
        s2_zero_q <= zero_w;
      end
    end
  end

  assign isq_valid = isq_valid_q;
  assign isq_x     = isq_x_q;

  // Components and the expected-valid bit ride alongside the inverse-sqrt stage.
  logic [ISQ_LAT-1:0]         dl_v_q, dl_z_q;
  logic [ISQ_LAT-1:0][VW-1:0] dl_c_q;
  logic                       err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dl_v_q <= '0;
      dl_z_q <= '0;
      dl_c_q <= '0;
      err_q  <= 1'b0;
    end else begin
      dl_v_q[0] <= isq_valid_q;
      dl_z_q[0] <= s2_zero_q;
      dl_c_q[0] <= s2_c_q;
      for (int i = 1; i < ISQ_LAT; i++) begin
        dl_v_q[i] <= dl_v_q[i-1];
        dl_z_q[i] <= dl_z_q[i-1];
        dl_c_q[i] <= dl_c_q[i-1];
      end
      err_q <= err_q | (isq_valid_in != dl_v_q[ISQ_LAT-1]);
    end
  end

  assign err = err_q;

  logic          push_w, degen_w;
  logic [VW-1:0] ent_w, head_c;

  assign push_w  = dl_v_q[ISQ_LAT-1];
  assign degen_w = dl_z_q[ISQ_LAT-1];
  assign head_c  = dl_c_q[ISQ_LAT-1];
  assign ent_w   = degen_w ? '0 : {scale(head_c[VW-1:2*WIDTH], isq_result),
                                   scale(head_c[2*WIDTH-1:WIDTH], isq_result),
                                   scale(head_c[WIDTH-1:0], isq_result)};

  logic [VW-1:0] mem_q [OUT_DEPTH];
  logic [CW-1:0] wr_q, rd_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < OUT_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_w) begin
        mem_q[wr_q[AW-1:0]] <= ent_w;
        wr_q <= wr_q + CW'(1);
      end
      if (pop) rd_q <= rd_q + CW'(1);
    end
  end

  assign out_valid = (wr_q != rd_q);
  assign out_x     = mem_q[rd_q[AW-1:0]][VW-1:2*WIDTH];
  assign out_y     = mem_q[rd_q[AW-1:0]][2*WIDTH-1:WIDTH];
  assign out_z     = mem_q[rd_q[AW-1:0]][WIDTH-1:0];

`ifdef NORM_DEGEN_FLAG_EN
  logic [OUT_DEPTH-1:0] deg_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) deg_q <= '0;
    else if (push_w) deg_q[wr_q[AW-1:0]] <= degen_w;
  end

  assign out_degen = deg_q[rd_q[AW-1:0]];
`endif

endmodule
`default_nettype wire

// File: tb/tb_vec3_normalize.sv
`default_nettype none
`timescale 1ns/1ps
// tb_vec3_normalize: directed and randomized checks against an arithmetic reference model.
module tb_vec3_normalize;
  localparam logic [31:0] XORK = 32'h00A5_5A00;

  logic        clk = 1'b0, rst = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b1;
  logic        in_ready, isq_valid, isq_valid_in, out_valid, err;
  logic [31:0] in_x = '0, in_y = '0, in_z = '0;
  logic [31:0] isq_x, isq_result, out_x, out_y, out_z;
`ifdef NORM_DEGEN_FLAG_EN
  logic        out_degen;
`endif

  vec3_normalize #(.WIDTH(32), .ISQ_LAT(2), .OUT_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_z(in_z),
    .isq_valid(isq_valid), .isq_x(isq_x),
    .isq_valid_in(isq_valid_in), .isq_result(isq_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_z(out_z),
`ifdef NORM_DEGEN_FLAG_EN
    .out_degen(out_degen),
`endif
    .err(err)
  );

  always #5 clk = ~clk;

  // Inverse-sqrt stub: fixed latency (adjustable for the mismatch test).
  int          stub_lat = 2;
  bit          stub_force = 1'b0;
  logic [31:0] stub_val = '0;
  logic [3:0]  sv;
  logic [31:0] sd [4];
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      sv <= '0;
      for (int i = 0; i < 4; i++) sd[i] <= '0;
    end else begin
      sv <= {sv[2:0], isq_valid};
      sd[0] <= isq_x;
      for (int i = 1; i < 4; i++) sd[i] <= sd[i-1];
    end
  end
  assign isq_valid_in = sv[stub_lat-1];
  assign isq_result   = stub_force ? stub_val : (sd[stub_lat-1] ^ XORK);

  int n_cmp = 0, n_mis = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference arithmetic in plain 64-bit integers.
  function automatic logic [31:0] term(input logic [31:0] c);
    longint s; logic [63:0] b;
    s = longint'($signed(c)) * longint'($signed(c));
    b = s;
    return (b[63:56] != 8'h0) ? 32'hFFFF_FFFF : b[55:24];
  endfunction
  function automatic logic [31:0] lensq(input logic [31:0] x, y, z);
    longint t; logic [63:0] b;
    t = longint'({32'h0, term(x)}) + longint'({32'h0, term(y)}) + longint'({32'h0, term(z)});
    b = t;
    return (t > 64'h0_FFFF_FFFF) ? 32'hFFFF_FFFF : b[31:0];
  endfunction
  function automatic logic [31:0] mscale(input logic [31:0] c, r);
    longint p; logic [63:0] b;
    p = longint'($signed(c)) * longint'({32'h0, r});
    b = p;
    return b[55:24];
  endfunction

  typedef struct { logic [31:0] x, y, z; logic d; } ent_t;
  logic [31:0] exp_isq [$];
  ent_t        exp_out [$];
  bit          sb_en = 1'b1;
  int          accepts = 0, pops = 0;
  logic [31:0] m_l, m_r;
  ent_t        m_e;

  always @(negedge clk) begin
    if (rst) begin
      if (in_valid && in_ready) begin
        accepts++;
        m_l = lensq(in_x, in_y, in_z);
        exp_isq.push_back(m_l);
        m_r = stub_force ? stub_val : (m_l ^ XORK);
        m_e.x = mscale(in_x, m_r); m_e.y = mscale(in_y, m_r); m_e.z = mscale(in_z, m_r); m_e.d = 1'b0;
`ifdef NORM_DEGEN_FLAG_EN
        if (m_l == 32'h0) begin m_e.x = '0; m_e.y = '0; m_e.z = '0; m_e.d = 1'b1; end
`endif
        exp_out.push_back(m_e);
      end
      if (isq_valid) begin
        if (exp_isq.size() == 0) begin
          if (sb_en) chk("isq_extra", isq_valid, 1'b0);
        end else begin
          m_l = exp_isq.pop_front();
          if (sb_en) chk("sb_isq_x", isq_x, m_l);
        end
      end
      if (out_valid && out_ready) begin
        pops++;
        if (exp_out.size() == 0) begin
          if (sb_en) chk("out_extra", out_valid, 1'b0);
        end else begin
          m_e = exp_out.pop_front();
          if (sb_en) begin
            chk("sb_out_x", out_x, m_e.x);
            chk("sb_out_y", out_y, m_e.y);
            chk("sb_out_z", out_z, m_e.z);
`ifdef NORM_DEGEN_FLAG_EN
            chk("sb_out_degen", out_degen, m_e.d);
`endif
          end
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [31:0] x, y, z);
    int g = 0;
    in_x = x; in_y = y; in_z = z; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && g < 200) begin @(negedge clk); g++; end
    if (g >= 200) chk("send_timeout", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic lat_check(input string tag, input logic [31:0] isq_e, ex, ey, ez);
    repeat (2) @(negedge clk);
    chk({tag, "_isq_valid"}, isq_valid, 1'b1);
    chk({tag, "_isq_x"}, isq_x, isq_e);
    repeat (2) @(negedge clk);
    chk({tag, "_early_valid"}, out_valid, 1'b0);
    @(negedge clk);
    chk({tag, "_out_valid"}, out_valid, 1'b1);
    chk({tag, "_out_x"}, out_x, ex);
    chk({tag, "_out_y"}, out_y, ey);
    chk({tag, "_out_z"}, out_z, ez);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    exp_isq.delete(); exp_out.delete();
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_err", err, 1'b0);
    @(negedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    int acc;
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, g;
    @(negedge clk);
    chk("init_in_ready", in_ready, 1'b0);
    chk("init_isq_valid", isq_valid, 1'b0);
    chk("init_out_valid", out_valid, 1'b0);
    chk("init_out_x", out_x, 32'h0);
    chk("init_err", err, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    stub_force = 1'b1; stub_val = 32'h0100_0000;
    send(32'h0100_0000, 32'h0, 32'h0);
    lat_check("unit", 32'h0100_0000, 32'h0100_0000, 32'h0, 32'h0);
    @(posedge clk); #1;

    stub_val = 32'h0033_3333;
    send(32'hFD00_0000, 32'h0400_0000, 32'h0);
    lat_check("345", 32'h1900_0000, 32'hFF66_6667, 32'h00CC_CCCC, 32'h0);
    @(posedge clk); #1;

    stub_val = 32'h0001_0000;
    send(32'h7FFF_FFFF, 32'h0, 32'h0);
    lat_check("sat", 32'hFFFF_FFFF, 32'h007F_FFFF, 32'h0, 32'h0);
    @(posedge clk); #1;

    stub_val = 32'h1234_5678;
    send(32'h0, 32'h0, 32'h0);
    lat_check("zero", 32'h0, 32'h0, 32'h0, 32'h0);
`ifdef NORM_DEGEN_FLAG_EN
    chk("zero_out_degen", out_degen, 1'b1);
`endif
    @(posedge clk); #1;

    // Backpressure: only OUT_DEPTH vectors may be in flight.
    stub_force = 1'b0; out_ready = 1'b0; acc = 0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_x = 32'h0010_0000 * (i + 1); in_y = 32'h0; in_z = 32'h0020_0000;
      @(negedge clk);
      if (in_ready) acc++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("bp_accepts", acc, 4);
    repeat (8) @(negedge clk);
    chk("bp_in_ready_low", in_ready, 1'b0);
    chk("bp_out_valid", out_valid, 1'b1);
    g = 0; acc = pops;
    out_ready = 1'b1;
    while (pops < acc + 4 && g < 50) begin @(negedge clk); g++; end
    chk("bp_drained", pops - acc, 4);
    @(negedge clk);
    chk("bp_in_ready_back", in_ready, 1'b1);
    chk("bp_queue_empty", exp_out.size(), 0);
    @(posedge clk); #1;

    // Reset with vectors outstanding.
    out_ready = 1'b0;
    send(32'h0100_0000, 32'h0, 32'h0);
    send(32'h0, 32'h0100_0000, 32'h0);
    send(32'h0, 32'h0, 32'h0100_0000);
    do_reset();
    out_ready = 1'b1;
    @(negedge clk);
    chk("mid_rst_in_ready", in_ready, 1'b1);
    repeat (6) @(negedge clk);
    chk("mid_rst_no_stale", out_valid, 1'b0);
    chk("mid_rst_err", err, 1'b0);
    @(posedge clk); #1;
    stub_force = 1'b1; stub_val = 32'h0080_0000;
    send(32'h0200_0000, 32'h0, 32'h0);
    lat_check("after_rst", 32'h0400_0000, 32'h0100_0000, 32'h0, 32'h0);
    @(posedge clk); #1;

    // Latency mismatch sets a sticky error.
    sb_en = 1'b0; stub_lat = 3;
    send(32'h0100_0000, 32'h0100_0000, 32'h0);
    repeat (8) @(negedge clk);
    chk("err_set", err, 1'b1);
    stub_lat = 2;
    repeat (5) @(negedge clk);
    chk("err_sticky", err, 1'b1);
    do_reset();
    @(negedge clk);
    chk("err_cleared", err, 1'b0);
    sb_en = 1'b1; stub_force = 1'b0;
    @(posedge clk); #1;

    // Randomized traffic with random output backpressure.
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(3) == 0) begin @(posedge clk); #1; end
          send($urandom, $urandom, $urandom);
        end
      end
      begin
        for (int i = 0; i < 700; i++) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(2) != 0);
        end
      end
    join_any
    disable fork;
    out_ready = 1'b1;
    g = 0;
    while (pops < accepts && g < 100) begin @(negedge clk); g++; end
    chk("rand_drain_left", exp_out.size(), 0);
    chk("rand_err", err, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
`default_nettype wire
